// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator driving the data memory's address, data and level enables.
// Store: resp at n+2+WE_CYCLES, ready at n+3+WE_CYCLES; load: resp at n+1+READ_CYCLES, ready one later.
// req_ready is high only in IDLE; the response is a pulse with no backpressure.
module load_store_unit #(
    parameter int D_ADDR_W    = 12,
    parameter int DATA_W      = 8,
    parameter int WE_CYCLES   = 1,
    parameter int READ_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [D_ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic                resp_write,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic [D_ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]   mem_write_data,
    output logic                mem_write_enable,
    output logic                mem_output_enable,
    input  logic [DATA_W-1:0]   mem_read_data
);

    localparam int CNT_MAX = (WE_CYCLES > READ_CYCLES) ? WE_CYCLES : READ_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_W_SETUP = 3'd1;
    localparam logic [2:0] S_W_PULSE = 3'd2;
    localparam logic [2:0] S_W_HOLD  = 3'd3;
    localparam logic [2:0] S_R_WAIT  = 3'd4;
    localparam logic [2:0] S_RESP    = 3'd5;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;

    // Every output is a flop updated alongside the state, so nothing on req_* reaches mem_* combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            cnt               <= '0;
            req_ready         <= 1'b1;
            resp_valid        <= 1'b0;
            resp_write        <= 1'b0;
            resp_rdata        <= '0;
            mem_addr          <= '0;
            mem_write_data    <= '0;
            mem_write_enable  <= 1'b0;
            mem_output_enable <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        mem_addr  <= req_addr;
                        if (req_write) begin
                            mem_write_data <= req_wdata;
                            state          <= S_W_SETUP;
                        end else begin
                            cnt               <= CNT_W'(READ_CYCLES);
                            mem_output_enable <= 1'b1;
                            state             <= S_R_WAIT;
                        end
                    end
                end
                S_W_SETUP: begin
                    cnt              <= CNT_W'(WE_CYCLES);
                    mem_write_enable <= 1'b1;
                    state            <= S_W_PULSE;
                end
                S_W_PULSE: begin
                    if (cnt == CNT_W'(1)) begin
                        cnt              <= '0;
                        mem_write_enable <= 1'b0;
                        resp_valid       <= 1'b1;
                        resp_write       <= 1'b1;
                        state            <= S_W_HOLD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_W_HOLD: begin
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                S_R_WAIT: begin
                    // Sample read data while output_enable is still asserted.
                    if (cnt == CNT_W'(1)) begin
                        cnt               <= '0;
                        resp_rdata        <= mem_read_data;
                        mem_output_enable <= 1'b0;
                        resp_valid        <= 1'b1;
                        resp_write        <= 1'b0;
                        state             <= S_RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    cnt               <= '0;
                    req_ready         <= 1'b1;
                    mem_write_enable  <= 1'b0;
                    mem_output_enable <= 1'b0;
                    state             <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: default instance plus a WE_CYCLES=3/READ_CYCLES=2 instance, each with a memory model.
// Directed vector table for timing/data, hand sequences for blocked requests and mid-write reset.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic        t_valid = 1'b0;
    logic        t_write = 1'b0;
    logic [11:0] t_addr = '0;
    logic [7:0]  t_wdata = '0;

    int total = 0;
    int bad   = 0;

    logic        rdy0, rv0, rw0, we0, oe0;
    logic [7:0]  rd0_q, wd0;
    logic [11:0] ad0;
    wire  [7:0]  mrd0;
    logic        rdy1, rv1, rw1, we1, oe1;
    logic [7:0]  rd1_q, wd1;
    logic [11:0] ad1;
    wire  [7:0]  mrd1;

    logic [7:0] mem0 [4096];
    logic [7:0] mem1 [4096];

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(t_valid & ~sel), .req_ready(rdy0), .req_write(t_write),
        .req_addr(t_addr), .req_wdata(t_wdata),
        .resp_valid(rv0), .resp_write(rw0), .resp_rdata(rd0_q),
        .mem_addr(ad0), .mem_write_data(wd0), .mem_write_enable(we0),
        .mem_output_enable(oe0), .mem_read_data(mrd0)
    );

    load_store_unit #(.WE_CYCLES(3), .READ_CYCLES(2)) dut_sweep (
        .clk(clk), .rst(rst),
        .req_valid(t_valid & sel), .req_ready(rdy1), .req_write(t_write),
        .req_addr(t_addr), .req_wdata(t_wdata),
        .resp_valid(rv1), .resp_write(rw1), .resp_rdata(rd1_q),
        .mem_addr(ad1), .mem_write_data(wd1), .mem_write_enable(we1),
        .mem_output_enable(oe1), .mem_read_data(mrd1)
    );

    always @(posedge clk) if (we0) mem0[ad0] <= wd0;
    always @(posedge clk) if (we1) mem1[ad1] <= wd1;
    assign mrd0 = oe0 ? mem0[ad0] : 8'bz;
    assign mrd1 = oe1 ? mem1[ad1] : 8'bz;

    logic        v_ready, v_rvalid, v_rwrite, v_we, v_oe;
    logic [7:0]  v_rdata, v_wd;
    logic [11:0] v_addr;
    assign v_ready  = sel ? rdy1  : rdy0;
    assign v_rvalid = sel ? rv1   : rv0;
    assign v_rwrite = sel ? rw1   : rw0;
    assign v_rdata  = sel ? rd1_q : rd0_q;
    assign v_addr   = sel ? ad1   : ad0;
    assign v_wd     = sel ? wd1   : wd0;
    assign v_we     = sel ? we1   : we0;
    assign v_oe     = sel ? oe1   : oe0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Invariants for both instances: exclusive enables, bus stable during WE and the cycle after it.
    logic        p_we0 = 1'b0, p_we1 = 1'b0;
    logic [11:0] p_ad0 = '0, p_ad1 = '0;
    logic [7:0]  p_wd0 = '0, p_wd1 = '0;
    always @(negedge clk) begin
        if (rst) begin
            p_we0 = 1'b0;
            p_we1 = 1'b0;
        end else begin
            if (we0 || oe0) check("enables_exclusive0", 32'(we0 & oe0), 32'd0);
            if (we1 || oe1) check("enables_exclusive1", 32'(we1 & oe1), 32'd0);
            if (we0 || p_we0) check("bus_stable0", {8'd0, p_ad0, p_wd0}, {8'd0, ad0, wd0});
            if (we1 || p_we1) check("bus_stable1", {8'd0, p_ad1, p_wd1}, {8'd0, ad1, wd1});
            p_we0 = we0; p_ad0 = ad0; p_wd0 = wd0;
            p_we1 = we1; p_ad1 = ad1; p_wd1 = wd1;
        end
    end

    // Called at a negedge with the selected DUT idle; returns at the negedge where ready is back.
    task automatic do_req(input logic w, input logic [11:0] a, input logic [7:0] d, input logic [7:0] exp);
        int we_c, rc, resp_at, we_cnt, oe_cnt;
        logic [11:0] setup_addr;
        logic [7:0]  setup_wd;
        we_c = sel ? 3 : 1;
        rc   = sel ? 2 : 1;
        resp_at = 0; we_cnt = 0; oe_cnt = 0;
        setup_addr = '0; setup_wd = '0;
        t_valid = 1'b1; t_write = w; t_addr = a; t_wdata = d;
        #1;
        check("ready_at_accept", 32'(v_ready), 32'd1);
        for (int c = 1; c <= 20 && resp_at == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                t_valid = 1'b0;
                setup_addr = v_addr;
                setup_wd = v_wd;
            end
            if (v_we) we_cnt++;
            if (v_oe) oe_cnt++;
            if (v_rvalid) begin
                resp_at = c;
                check("resp_write", 32'(v_rwrite), 32'(w));
                if (w) begin
                    check("addr_after_we", 32'(v_addr), 32'(a));
                    check("oe_in_store", 32'(oe_cnt), 32'd0);
                end else begin
                    check("resp_rdata", 32'(v_rdata), 32'(exp));
                    check("oe_off_in_resp", 32'(v_oe), 32'd0);
                end
            end
        end
        check("resp_latency", 32'(resp_at), w ? 32'(2 + we_c) : 32'(1 + rc));
        check("we_cycles", 32'(we_cnt), w ? 32'(we_c) : 32'd0);
        check("oe_cycles", 32'(oe_cnt), w ? 32'd0 : 32'(rc));
        check("addr_before_we", 32'(setup_addr), 32'(a));
        if (w) check("wdata_before_we", 32'(setup_wd), 32'(d));
        @(negedge clk);
        check("ready_back", 32'(v_ready), 32'd1);
        check("no_extra_resp", 32'(v_rvalid), 32'd0);
        if (w) check("mem_model", 32'(sel ? mem1[a] : mem0[a]), 32'(d));
    endtask

    typedef struct {
        logic        sel;
        logic        w;
        logic [11:0] a;
        logic [7:0]  d;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[13];

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'({rdy0, rdy1}), 32'h3);
        check({tag, "_resp"}, 32'({rv0, rw0, rv1, rw1}), 32'h0);
        check({tag, "_rdata"}, {16'd0, rd0_q, rd1_q}, 32'h0);
        check({tag, "_bus0"}, {12'd0, ad0, wd0}, 32'h0);
        check({tag, "_bus1"}, {12'd0, ad1, wd1}, 32'h0);
        check({tag, "_en"}, 32'({we0, oe0, we1, oe1}), 32'h0);
    endtask

    initial begin
        int acc_at, resp_cnt, extra;
        vecs[0]  = '{1'b0, 1'b1, 12'h123, 8'hA5, 8'h00};
        vecs[1]  = '{1'b0, 1'b0, 12'h123, 8'h00, 8'hA5};
        vecs[2]  = '{1'b0, 1'b1, 12'h000, 8'h00, 8'h00};
        vecs[3]  = '{1'b0, 1'b1, 12'hFFF, 8'hFF, 8'h00};
        vecs[4]  = '{1'b0, 1'b0, 12'h000, 8'h00, 8'h00};
        vecs[5]  = '{1'b0, 1'b0, 12'hFFF, 8'h00, 8'hFF};
        vecs[6]  = '{1'b0, 1'b1, 12'h000, 8'h5A, 8'h00};
        vecs[7]  = '{1'b0, 1'b0, 12'hFFF, 8'h00, 8'hFF};
        vecs[8]  = '{1'b0, 1'b0, 12'h000, 8'h00, 8'h5A};
        vecs[9]  = '{1'b1, 1'b1, 12'h0AB, 8'h3C, 8'h00};
        vecs[10] = '{1'b1, 1'b0, 12'h0AB, 8'h00, 8'h3C};
        vecs[11] = '{1'b1, 1'b1, 12'hFFF, 8'h81, 8'h00};
        vecs[12] = '{1'b1, 1'b0, 12'hFFF, 8'h00, 8'h81};

        repeat (3) @(negedge clk);
        check_reset_outputs("in_reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("after_reset");

        foreach (vecs[i]) begin
            sel = vecs[i].sel;
            do_req(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp);
        end

        // Load held against a busy store: accepted exactly when ready returns, one response each.
        sel = 1'b0;
        t_valid = 1'b1; t_write = 1'b1; t_addr = 12'h200; t_wdata = 8'h11;
        #1;
        check("blk_first_ready", 32'(v_ready), 32'd1);
        @(negedge clk);
        t_write = 1'b0; t_wdata = 8'hEE;
        acc_at = 0; resp_cnt = 0;
        for (int c = 1; c <= 20 && acc_at == 0; c++) begin
            if (v_rvalid) resp_cnt++;
            if (v_ready) acc_at = c;
            else @(negedge clk);
        end
        check("blk_accept_cycle", 32'(acc_at), 32'd4);
        check("blk_store_resp_cnt", 32'(resp_cnt), 32'd1);
        @(negedge clk);
        t_valid = 1'b0;
        check("blk_oe", 32'(oe0), 32'd1);
        @(negedge clk);
        check("blk_load_resp", {23'd0, rv0, rd0_q}, {23'd0, 1'b1, 8'h11});
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rv0) extra++;
        end
        check("blk_no_dup", 32'(extra), 32'd0);

        // Reset in the middle of the write pulse.
        t_valid = 1'b1; t_write = 1'b1; t_addr = 12'h300; t_wdata = 8'h77;
        @(negedge clk);
        t_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mid_we_high", 32'(we0), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_we_drop", 32'(we0), 32'd0);
        check("rst_addr_clear", 32'(ad0), 32'd0);
        check("rst_ready", 32'(rdy0), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("after_abort");
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rv0) extra++;
        end
        check("abort_no_resp", 32'(extra), 32'd0);

        sel = 1'b0;
        do_req(1'b0, 12'h123, 8'h00, 8'hA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Core-side initiator for the data memory bus. Accepts one load or store at a time from the CPU core over a valid/ready handshake. Sequences the memory's level-sensitive `write_enable`/`output_enable` controls with a fixed address setup and hold around every write strobe. Returns completion, and read data for loads, on a single-cycle response pulse. Sits between the execute stage and `data_memory`, and is the only driver of that memory's address, data and enable inputs.

## Interface
- `D_ADDR_W`, 12, data address width; matches the memory.
- `DATA_W`, 8, data word width.
- `WE_CYCLES`, 1, width of the `write_enable` pulse in cycles; must be ≥1.
- `READ_CYCLES`, 1, cycles `output_enable` is held before read data is sampled; must be ≥1.

Ports:
- `clk` in 1: sole clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: core request present.
- `req_ready` out 1: unit can accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in D_ADDR_W: target address.
- `req_wdata` in DATA_W: store data; ignored for loads.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_write` out 1: type of the completing request.
- `resp_rdata` out DATA_W: load result; holds until the next load completes.
- `mem_addr` out D_ADDR_W: to memory `data_addr`.
- `mem_write_data` out DATA_W: to memory `write_data`.
- `mem_write_enable` out 1: to memory `write_enable`.
- `mem_output_enable` out 1: to memory `output_enable`.
- `mem_read_data` in DATA_W: from memory `read_data`; is Z when the memory is not reading.

## Operation
- States: IDLE, W_SETUP, W_PULSE, W_HOLD, R_WAIT, RESP. A down-counter sized `$clog2(max(WE_CYCLES,READ_CYCLES)+1)` times W_PULSE and R_WAIT.
- **IDLE:** `req_ready`=1, all enables 0. On `req_valid && req_ready`, latch address, data and type.
  - Store → W_SETUP.
  - Load → R_WAIT, with counter = READ_CYCLES.
- **W_SETUP (1 cycle):** `mem_addr`/`mem_write_data` drive the latched values; `mem_write_enable`=0. Next state W_PULSE, counter = WE_CYCLES.
- **W_PULSE (WE_CYCLES cycles):** `mem_write_enable`=1. When the counter expires → W_HOLD.
- **W_HOLD (1 cycle):** `mem_write_enable`=0; address and data unchanged; `resp_valid`=1, `resp_write`=1. Next state IDLE.
- **R_WAIT (READ_CYCLES cycles):** `mem_output_enable`=1. On the last cycle, capture `mem_read_data` into `resp_rdata` → RESP.
- **RESP (1 cycle):** `mem_output_enable`=0; `resp_valid`=1, `resp_write`=0. Next state IDLE.
- `req_ready` is 1 only in IDLE. No response backpressure.
- Invariants:
  - `mem_write_enable` and `mem_output_enable` are never both 1.
  - `mem_addr`/`mem_write_data` never change while `mem_write_enable`=1, nor in the cycle before or after it.
- In IDLE, `mem_addr`/`mem_write_data` hold their last values.
- Addresses are unchecked; the full D_ADDR_W range is legal, with no wrap logic.
- All outputs are registered; no combinational path from `req_*` to `mem_*`.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - `req_ready`=1.
  - `resp_valid`=0, `resp_write`=0, `resp_rdata`=0.
  - `mem_addr`=0, `mem_write_data`=0.
  - `mem_write_enable`=0, `mem_output_enable`=0.
- With the handshake in cycle n:
  - **Store:** W_SETUP in n+1; WE high in n+2 … n+1+WE_CYCLES; `resp_valid` in n+2+WE_CYCLES; `req_ready` back in n+3+WE_CYCLES.
  - **Load:** OE high in n+1 … n+READ_CYCLES; `resp_valid` with data in n+1+READ_CYCLES; `req_ready` back in n+2+READ_CYCLES.
- Default parameters:
  - Store occupancy is 4 cycles (n+1..n+4), so the next accept is at n+4.
  - Load occupancy is 3 cycles (n+1..n+3), so the next accept is at n+3.
- Reset asserted mid-operation:
  - All outputs take reset values immediately and asynchronously; WE and OE drop at once.
  - An interrupted store may partially update memory; this is acceptable.
  - No response is issued for the aborted request.
- `req_valid` asserted while `req_ready`=0 is ignored; the core must hold it until accepted.

## Test plan
- **Reset:** `rst`=1 mid-W_PULSE → `mem_write_enable`=0 in the same cycle. After release, `req_ready`=1 and all outputs are 0.
- **Single store, defaults:** addr 0x123, data 0xA5.
  - `mem_addr`=0x123 one cycle before WE and one cycle after.
  - WE high exactly 1 cycle.
  - `resp_valid`/`resp_write`=1 at n+3.
  - A memory model reads back 0xA5.
- **Store then load:** same address, back to back → load `resp_rdata`=0xA5 at the expected cycle. OE and WE are never both high.
- **Parameter sweep:** WE_CYCLES=3, READ_CYCLES=2 → WE high 3 cycles; store response at n+5; load response at n+3 with correct data.
- **Boundary addresses:** addresses 0x000 and 0xFFF with data 0x00 and 0xFF → correct readback; no aliasing between the two.
- **Blocked request:** `req_valid` held during a busy store → accepted exactly on the first cycle `req_ready`=1. No request is lost or duplicated.
